// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates credit, vends on select, returns change, refunds on cancel/timeout.
// Latency: all outputs registered; a vend pulses one cycle after the accepted select, change one cycle after that.
// Backpressure: none; coins arriving while they cannot be taken (VEND/CHANGE, overflow, dropped) pulse coin_reject.
//
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   coin_valid, coin_value         coin / top-up strobe and its value
//   select_valid, select_product   product selection strobe and index
//   cancel                         refund request
//   dispense_valid, dispense_id    one-cycle vend pulse and product index
//   change_valid, change           one-cycle change pulse and amount
//   balance                        current credit
//   coin_reject, insufficient,
//   invalid_sel                    one-cycle status pulses
//   busy                           high while vending or paying out change
module vending_machine_param #(
   parameter int MONEY_W        = 8,
   parameter int NUM_PRODUCTS   = 4,
   parameter int SEL_W          = 2,
   parameter logic [NUM_PRODUCTS*MONEY_W-1:0] PRICES = {8'd20, 8'd15, 8'd10, 8'd5},
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               coin_valid,
   input  logic [MONEY_W-1:0] coin_value,
   input  logic               select_valid,
   input  logic [SEL_W-1:0]   select_product,
   input  logic               cancel,
   output logic               dispense_valid,
   output logic [SEL_W-1:0]   dispense_id,
   output logic               change_valid,
   output logic [MONEY_W-1:0] change,
   output logic [MONEY_W-1:0] balance,
   output logic               coin_reject,
   output logic               insufficient,
   output logic               invalid_sel,
   output logic               busy
);

   localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   // Timer value seen on the last idle cycle before the refund fires.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SEL_W:0]   NUM_SEL  = (SEL_W + 1)'(NUM_PRODUCTS);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   state_t             state, state_next;
   logic [TMR_W-1:0]   timer, timer_next;
   logic [MONEY_W-1:0] balance_next;
   logic               dispense_valid_next;
   logic [SEL_W-1:0]   dispense_id_next;
   logic               change_valid_next;
   logic [MONEY_W-1:0] change_next;
   logic               coin_reject_next;
   logic               insufficient_next;
   logic               invalid_sel_next;

   // Price table padded to the full index space so any select_product indexes
   // it safely; unused entries are never reached because sel_legal gates them.
   logic [MONEY_W-1:0] price_tbl [2**SEL_W];

   for (genvar i = 0; i < 2**SEL_W; i++) begin : g_price
      if (i < NUM_PRODUCTS) begin : g_used
         assign price_tbl[i] = PRICES[i*MONEY_W +: MONEY_W];
      end else begin : g_unused
         assign price_tbl[i] = '0;
      end
   end

   logic               sel_legal;
   logic [MONEY_W-1:0] sel_price;
   logic [MONEY_W-1:0] vend_price;
   logic [MONEY_W:0]   coin_sum;
   logic [MONEY_W-1:0] remainder;

   assign sel_legal = ({1'b0, select_product} < NUM_SEL);
   assign sel_price = price_tbl[select_product];
   // dispense_id holds the latched product for exactly the VEND cycle.
   assign vend_price = price_tbl[dispense_id];
   // One extra bit so an overflowing top-up is detected rather than wrapped.
   assign coin_sum   = {1'b0, balance} + {1'b0, coin_value};
   assign remainder  = balance - vend_price;

   always_comb begin
      state_next          = state;
      balance_next        = balance;
      timer_next          = '0;
      dispense_valid_next = 1'b0;
      dispense_id_next    = '0;
      change_valid_next   = 1'b0;
      change_next         = '0;
      coin_reject_next    = 1'b0;
      insufficient_next   = 1'b0;
      invalid_sel_next    = 1'b0;

      case (state)
         IDLE: begin
            // Coin and select are independent here: a select cannot consume
            // credit that does not exist yet, so it only reports a flag.
            if (coin_valid && (coin_value != '0)) begin
               balance_next = coin_value;
               state_next   = CREDIT;
            end
            if (select_valid) begin
               if (sel_legal) insufficient_next = 1'b1;
               else           invalid_sel_next  = 1'b1;
            end
         end

         CREDIT: begin
            // Single event per cycle: cancel > select > coin. A coin that
            // loses to a higher-priority event is rejected, not kept.
            if (cancel) begin
               change_valid_next = 1'b1;
               change_next       = balance;
               coin_reject_next  = coin_valid;
               state_next        = CHANGE;
            end else if (select_valid) begin
               coin_reject_next = coin_valid;
               if (!sel_legal) begin
                  invalid_sel_next = 1'b1;
               end else if (balance < sel_price) begin
                  insufficient_next = 1'b1;
               end else begin
                  dispense_valid_next = 1'b1;
                  dispense_id_next    = select_product;
                  state_next          = VEND;
               end
            end else if (coin_valid) begin
               if (coin_sum[MONEY_W]) coin_reject_next = 1'b1;
               else                   balance_next     = coin_sum[MONEY_W-1:0];
            end else if (timer == TMR_LAST) begin
               change_valid_next = 1'b1;
               change_next       = balance;
               state_next        = CHANGE;
            end else begin
               timer_next = timer + TMR_W'(1);
            end
         end

         VEND: begin
            coin_reject_next = coin_valid;
            balance_next     = remainder;
            if (remainder != '0) begin
               change_valid_next = 1'b1;
               change_next       = remainder;
               state_next        = CHANGE;
            end else begin
               state_next = IDLE;
            end
         end

         CHANGE: begin
            coin_reject_next = coin_valid;
            balance_next     = '0;
            state_next       = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         timer          <= '0;
         balance        <= '0;
         dispense_valid <= 1'b0;
         dispense_id    <= '0;
         change_valid   <= 1'b0;
         change         <= '0;
         coin_reject    <= 1'b0;
         insufficient   <= 1'b0;
         invalid_sel    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         state          <= state_next;
         timer          <= timer_next;
         balance        <= balance_next;
         dispense_valid <= dispense_valid_next;
         dispense_id    <= dispense_id_next;
         change_valid   <= change_valid_next;
         change         <= change_next;
         coin_reject    <= coin_reject_next;
         insufficient   <= insufficient_next;
         invalid_sel    <= invalid_sel_next;
         busy           <= (state_next == VEND) || (state_next == CHANGE);
      end
   end

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: two instances (4 products / timeout 16, 3 products / timeout 5)
// share one stimulus stream; a transaction-level credit model predicts every output after every edge.
// Directed scenarios first, then randomized coins/selects/cancels/resets with idle gaps.
module tb_vending_machine_param;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       coin_valid = 1'b0;
   logic [7:0] coin_value = '0;
   logic       select_valid = 1'b0;
   logic [1:0] select_product = '0;
   logic       cancel = 1'b0;

   logic       dv   [2];
   logic [1:0] did  [2];
   logic       cv   [2];
   logic [7:0] chg  [2];
   logic [7:0] bal  [2];
   logic       rej  [2];
   logic       ins  [2];
   logic       inv  [2];
   logic       bsy  [2];

   always #5 clock = ~clock;

   vending_machine_param u0 (
      .clock(clock), .reset(reset),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .select_valid(select_valid), .select_product(select_product), .cancel(cancel),
      .dispense_valid(dv[0]), .dispense_id(did[0]),
      .change_valid(cv[0]), .change(chg[0]), .balance(bal[0]),
      .coin_reject(rej[0]), .insufficient(ins[0]), .invalid_sel(inv[0]), .busy(bsy[0])
   );

   vending_machine_param #(
      .NUM_PRODUCTS(3),
      .PRICES({8'd15, 8'd10, 8'd5}),
      .TIMEOUT_CYCLES(5)
   ) u1 (
      .clock(clock), .reset(reset),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .select_valid(select_valid), .select_product(select_product), .cancel(cancel),
      .dispense_valid(dv[1]), .dispense_id(did[1]),
      .change_valid(cv[1]), .change(chg[1]), .balance(bal[1]),
      .coin_reject(rej[1]), .insufficient(ins[1]), .invalid_sel(inv[1]), .busy(bsy[1])
   );

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_CHANGE = 3;
   localparam int NPROD [2] = '{4, 3};
   localparam int TMO   [2] = '{16, 5};

   int m_mode [2];
   int m_bal  [2];
   int m_idle [2];
   int m_pid  [2];
   int e_dv [2], e_did [2], e_cv [2], e_chg [2], e_rej [2], e_ins [2], e_inv [2], e_bsy [2];

   int checks  = 0;
   int errors  = 0;
   int step_no = 0;

   // Product i costs 5*(i+1) on both instances.
   function automatic int price(input int i);
      return 5 * (i + 1);
   endfunction

   task automatic model_step(input int k, input bit r, input bit c_v, input int c_val,
                             input bit s_v, input int s, input bit can);
      e_dv[k] = 0; e_did[k] = 0; e_cv[k] = 0; e_chg[k] = 0;
      e_rej[k] = 0; e_ins[k] = 0; e_inv[k] = 0;
      if (r) begin
         m_mode[k] = M_IDLE; m_bal[k] = 0; m_idle[k] = 0; m_pid[k] = 0;
      end else begin
         case (m_mode[k])
            M_IDLE: begin
               if (c_v && c_val != 0) begin
                  m_bal[k] = c_val; m_mode[k] = M_CREDIT; m_idle[k] = 0;
               end
               if (s_v) begin
                  if (s < NPROD[k]) e_ins[k] = 1;
                  else              e_inv[k] = 1;
               end
            end
            M_CREDIT: begin
               if (can) begin
                  e_cv[k] = 1; e_chg[k] = m_bal[k]; e_rej[k] = c_v; m_mode[k] = M_CHANGE;
               end else if (s_v) begin
                  m_idle[k] = 0; e_rej[k] = c_v;
                  if (s >= NPROD[k])            e_inv[k] = 1;
                  else if (m_bal[k] < price(s)) e_ins[k] = 1;
                  else begin
                     e_dv[k] = 1; e_did[k] = s; m_pid[k] = s; m_mode[k] = M_VEND;
                  end
               end else if (c_v) begin
                  m_idle[k] = 0;
                  if (m_bal[k] + c_val > 255) e_rej[k] = 1;
                  else                        m_bal[k] = m_bal[k] + c_val;
               end else begin
                  m_idle[k] = m_idle[k] + 1;
                  if (m_idle[k] == TMO[k]) begin
                     e_cv[k] = 1; e_chg[k] = m_bal[k]; m_mode[k] = M_CHANGE;
                  end
               end
            end
            M_VEND: begin
               e_rej[k] = c_v;
               m_bal[k] = m_bal[k] - price(m_pid[k]);
               if (m_bal[k] != 0) begin
                  e_cv[k] = 1; e_chg[k] = m_bal[k]; m_mode[k] = M_CHANGE;
               end else begin
                  m_mode[k] = M_IDLE;
               end
            end
            default: begin
               e_rej[k] = c_v; m_bal[k] = 0; m_mode[k] = M_IDLE;
            end
         endcase
      end
      e_bsy[k] = (m_mode[k] == M_VEND || m_mode[k] == M_CHANGE) ? 1 : 0;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input int k, input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL step %0d u%0d %s observed=%0d expected=%0d", step_no, k, name, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk(k, "dispense_valid", 32'(dv[k]),  e_dv[k]);
         chk(k, "dispense_id",    32'(did[k]), e_did[k]);
         chk(k, "change_valid",   32'(cv[k]),  e_cv[k]);
         chk(k, "change",         32'(chg[k]), e_chg[k]);
         chk(k, "balance",        32'(bal[k]), m_bal[k]);
         chk(k, "coin_reject",    32'(rej[k]), e_rej[k]);
         chk(k, "insufficient",   32'(ins[k]), e_ins[k]);
         chk(k, "invalid_sel",    32'(inv[k]), e_inv[k]);
         chk(k, "busy",           32'(bsy[k]), e_bsy[k]);
      end
   endtask

   task automatic step(input bit r, input bit c_v, input int c_val,
                       input bit s_v, input int s, input bit can);
      reset          = r;
      coin_valid     = c_v;
      coin_value     = 8'(c_val);
      select_valid   = s_v;
      select_product = 2'(s);
      cancel         = can;
      @(posedge clock);
      for (int k = 0; k < 2; k++) model_step(k, r, c_v, c_val, s_v, s, can);
      #1;
      step_no++;
      check_all();
   endtask

   task automatic do_reset();          step(1, 0, 0, 0, 0, 0); endtask
   task automatic do_idle();           step(0, 0, 0, 0, 0, 0); endtask
   task automatic do_coin(input int v); step(0, 1, v, 0, 0, 0); endtask
   task automatic do_sel(input int s);  step(0, 0, 0, 1, s, 0); endtask
   task automatic do_cancel();         step(0, 0, 0, 0, 0, 1); endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      do_reset();
      chk(0, "rst_balance", 32'(bal[0]), 0);
      chk(0, "rst_busy",    32'(bsy[0]), 0);
      do_idle();

      // Vend with change: 10+10, product 2 (15) -> dispense 2, change 5
      do_coin(10);
      do_coin(10);
      do_sel(2);
      chk(0, "vend_pulse", 32'(dv[0]),  1);
      chk(0, "vend_id",    32'(did[0]), 2);
      do_idle();
      chk(0, "vend_change_valid", 32'(cv[0]),  1);
      chk(0, "vend_change",       32'(chg[0]), 5);
      do_idle();
      chk(0, "vend_bal_after", 32'(bal[0]), 0);
      chk(0, "vend_busy_after", 32'(bsy[0]), 0);

      // Top-up: 5, select 3 (20) -> insufficient; +15, select 3 -> exact vend
      do_coin(5);
      do_sel(3);
      chk(0, "topup_insufficient", 32'(ins[0]), 1);
      chk(1, "topup_invalid_n3",   32'(inv[1]), 1);
      chk(0, "topup_bal_kept",     32'(bal[0]), 5);
      do_coin(15);
      do_sel(3);
      chk(0, "topup_vend_id", 32'(did[0]), 3);
      do_idle();
      chk(0, "topup_no_change", 32'(cv[0]),  0);
      chk(0, "topup_bal_zero",  32'(bal[0]), 0);
      do_cancel();
      chk(1, "n3_refund", 32'(chg[1]), 20);
      do_idle();

      // Cancel: 20+5 then cancel -> change 25 next cycle
      do_coin(20);
      do_coin(5);
      do_cancel();
      chk(0, "cancel_change", 32'(chg[0]), 25);
      do_idle();
      // Cancel and select together -> refund only
      do_coin(10);
      step(0, 0, 0, 1, 0, 1);
      chk(0, "cancel_sel_no_vend", 32'(dv[0]), 0);
      chk(0, "cancel_sel_refund",  32'(chg[0]), 10);
      do_idle();

      // Timeout: coin 5 then idle; refund lands after exactly 16 idle edges
      do_coin(5);
      for (int i = 1; i <= 16; i++) begin
         do_idle();
         chk(0, $sformatf("timeout_cv_%0d", i), 32'(cv[0]), (i == 16) ? 1 : 0);
      end
      chk(0, "timeout_change", 32'(chg[0]), 5);
      do_idle();

      // Overflow: 250 + 10 rejected, 250 + 5 = 255 accepted, 255 + 1 rejected
      do_coin(200);
      do_coin(50);
      do_coin(10);
      chk(0, "ovf_reject", 32'(rej[0]), 1);
      chk(0, "ovf_bal",    32'(bal[0]), 250);
      do_coin(5);
      chk(0, "max_accept", 32'(bal[0]), 255);
      do_coin(1);
      chk(0, "max_reject", 32'(rej[0]), 1);
      do_cancel();
      do_idle();

      // Reset during VEND: no change pulse, everything back to 0, then coin 10
      do_coin(20);
      do_sel(0);
      do_reset();
      chk(0, "rst_vend_no_change", 32'(cv[0]),  0);
      chk(0, "rst_vend_balance",   32'(bal[0]), 0);
      do_coin(10);
      chk(0, "post_rst_balance", 32'(bal[0]), 10);
      do_cancel();
      do_idle();

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         int r, val;
         bit c_v, s_v, can, rst;
         r   = int'($urandom_range(0, 99));
         rst = (r < 2);
         c_v = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 7))
            0: val = 0;    1: val = 1;   2: val = 5;   3: val = 10;
            4: val = 20;   5: val = 50;  6: val = 100; default: val = 200;
         endcase
         s_v = ($urandom_range(0, 4) == 0);
         can = ($urandom_range(0, 14) == 0);
         step(rst, c_v, val, s_v, int'($urandom_range(0, 3)), can);
         if ($urandom_range(0, 19) == 0) begin
            int gap;
            gap = int'($urandom_range(1, 18));
            for (int g = 0; g < gap; g++) do_idle();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised next-generation vending controller with configurable product count, per-product prices and money width.
- Accumulates credit from coins and top-ups, vends on select, then returns change.
- Adds cancel/refund, inactivity timeout, overflow coin rejection and invalid-selection flags.
- Sits between the coin/keypad front end and the dispenser/change hopper drivers.

Parameters:
- MONEY_W, 8, width of coin_value, balance, change and prices.
- NUM_PRODUCTS, 4, number of products; legal range 2..2**SEL_W.
- SEL_W, 2, width of select_product and dispense_id.
- PRICES, {8'd20,8'd15,8'd10,8'd5}, packed NUM_PRODUCTS*MONEY_W vector; product i price is PRICES[i*MONEY_W +: MONEY_W]; every price must be nonzero.
- TIMEOUT_CYCLES, 16, idle cycles in CREDIT before automatic refund; must be >= 1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin or top-up present this cycle.
- coin_value  in  MONEY_W  value of the inserted coin.
- select_valid  in  1  product selection strobe.
- select_product  in  SEL_W  selected product index.
- cancel  in  1  refund request.
- dispense_valid  out  1  one-cycle vend pulse.
- dispense_id  out  SEL_W  product being vended.
- change_valid  out  1  one-cycle change pulse.
- change  out  MONEY_W  change amount.
- balance  out  MONEY_W  current credit.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- insufficient  out  1  one-cycle pulse: credit below price.
- invalid_sel  out  1  one-cycle pulse: index >= NUM_PRODUCTS.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Output timing: all outputs are registered. Every output resets to 0 on the edge where reset=1, and state resets to IDLE. Reset mid-operation aborts any pending vend or change with no pulse.
- States: IDLE, CREDIT, VEND, CHANGE.
- IDLE:
  - coin_valid with coin_value != 0: balance <= coin_value, go to CREDIT.
  - coin_value == 0: ignored.
  - Valid select: insufficient pulse.
  - Invalid select: invalid_sel pulse.
  - cancel: ignored.
- CREDIT: one event is processed per cycle, in priority order cancel > select > coin.
  - cancel: go to CHANGE.
  - select, index >= NUM_PRODUCTS: invalid_sel pulse, stay.
  - select, balance < price: insufficient pulse, stay.
  - select, balance >= price: latch id, go to VEND.
  - coin: computed in MONEY_W+1 bits. If the sum exceeds 2**MONEY_W-1, pulse coin_reject and leave balance unchanged; otherwise add it.
  - A lower-priority event in the same cycle as a higher one is dropped. A dropped coin pulses coin_reject.
- Timeout:
  - The timeout counter clears on any accepted coin or select event, including rejected or insufficient outcomes.
  - The counter increments on every CREDIT cycle without an event.
  - On reaching TIMEOUT_CYCLES, go to CHANGE.
- VEND (one cycle):
  - dispense_valid=1, dispense_id=latched id.
  - balance <= balance - price.
  - Next state is CHANGE if the remainder is nonzero, else IDLE.
- CHANGE (one cycle):
  - change_valid=1, change=balance.
  - balance <= 0, go to IDLE.
- Inputs during VEND/CHANGE: coins get coin_reject; select and cancel are ignored.
- Latency: a select accepted at edge k gives dispense_valid high in cycle k+1 and change_valid high in cycle k+2. A cancel at edge k gives change_valid in cycle k+1.
- Output values when idle: change and dispense_id are 0 when their valid is low.

Test Plan:
- Vend with change: coin 10, coin 10, select 2 -> dispense_valid with id=2 one cycle after the select edge, then change_valid with change=5; balance=0; back to IDLE.
- Top-up path: coin 5, select 3 -> insufficient pulse, balance stays 5. Then coin 15, select 3 -> dispense id=3, no change_valid, balance=0.
- Cancel: coins 20+5 then cancel -> change_valid with change=25 next cycle. Cancel and select in the same cycle -> refund only, no dispense.
- Timeout: coin 5, then inputs idle -> change_valid with change=5 exactly TIMEOUT_CYCLES+1 cycles after the coin edge.
- Overflow and invalid select:
  - balance 250, coin 10 -> coin_reject, balance stays 250.
  - With NUM_PRODUCTS=3, select 3 -> invalid_sel pulse, state stays CREDIT.
- Reset: assert reset in the VEND cycle -> no change_valid, all outputs 0 next cycle, IDLE. A coin 10 after reset -> balance=10.
